// File: rtl/register_write_arbiter.sv
// Register-file write-port arbiter: ALU results have absolute priority, and load
// results queue in a small FIFO with a zero-latency bypass when the FIFO is idle.
module register_write_arbiter #(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int DEPTH         = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [ADDRESS_WIDTH-1:0]      alu_address,
    input  logic [WORD_WIDTH-1:0]         alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [ADDRESS_WIDTH-1:0]      mem_address,
    input  logic [WORD_WIDTH-1:0]         mem_data,
    output logic                          write,
    output logic [ADDRESS_WIDTH-1:0]      write_address,
    output logic [WORD_WIDTH-1:0]         write_data,
    output logic [2**ADDRESS_WIDTH-1:0]   busy,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;
    localparam int REGS    = 2**ADDRESS_WIDTH;

    logic [ADDRESS_WIDTH-1:0] fifo_addr_r [DEPTH];
    logic [WORD_WIDTH-1:0]    fifo_data_r [DEPTH];
    logic [DEPTH-1:0]         fifo_valid_r;
    logic [PTR_W-1:0]         wr_ptr_r;
    logic [PTR_W-1:0]         rd_ptr_r;
    logic [COUNT_W-1:0]       count_r;
    logic [REGS-1:0]          busy_r;
    logic                     write_r;
    logic [ADDRESS_WIDTH-1:0] write_address_r;
    logic [WORD_WIDTH-1:0]    write_data_r;

    logic                     pop_s;
    logic                     mem_ready_s;
    logic                     accept_s;
    logic                     bypass_s;
    logic                     push_s;
    logic                     sel_valid_s;
    logic [ADDRESS_WIDTH-1:0] sel_addr_s;
    logic [WORD_WIDTH-1:0]    sel_data_s;
    logic [DEPTH-1:0]         valid_next_s;
    logic [REGS-1:0]          busy_next_s;

    // Handshake: the head drains whenever the ALU is idle, which frees a slot in the same cycle.
    always_comb begin
        pop_s       = !reset && !alu_valid && (count_r != {COUNT_W{1'b0}});
        mem_ready_s = !reset && ((count_r < COUNT_W'(DEPTH)) || pop_s);
        accept_s    = mem_valid && mem_ready_s;
        bypass_s    = accept_s && !alu_valid && (count_r == {COUNT_W{1'b0}});
        push_s      = accept_s && !bypass_s;
    end

    // Write-port selection: ALU, then FIFO head, then bypassed load.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_addr_s  = {ADDRESS_WIDTH{1'b0}};
        sel_data_s  = {WORD_WIDTH{1'b0}};
        if (alu_valid) begin
            sel_valid_s = 1'b1;
            sel_addr_s  = alu_address;
            sel_data_s  = alu_data;
        end else if (pop_s) begin
            sel_valid_s = 1'b1;
            sel_addr_s  = fifo_addr_r[rd_ptr_r];
            sel_data_s  = fifo_data_r[rd_ptr_r];
        end else if (bypass_s) begin
            sel_valid_s = 1'b1;
            sel_addr_s  = mem_address;
            sel_data_s  = mem_data;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // Next-state occupancy and scoreboard; register 0 is never marked busy.
    always_comb begin
        valid_next_s = (fifo_valid_r & ~(DEPTH'(pop_s) << rd_ptr_r))
                     | (DEPTH'(push_s) << wr_ptr_r);
        busy_next_s  = {REGS{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            busy_next_s[(push_s && (wr_ptr_r == PTR_W'(i))) ? mem_address : fifo_addr_r[i]] =
                busy_next_s[(push_s && (wr_ptr_r == PTR_W'(i))) ? mem_address : fifo_addr_r[i]]
                | valid_next_s[i];
        end
        busy_next_s[0] = 1'b0;
    end

    // FIFO payload storage; contents are only meaningful under fifo_valid_r.
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= mem_address;
            fifo_data_r[wr_ptr_r] <= mem_data;
        end
    end

    // FIFO control state: pointers, occupancy and busy scoreboard.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {COUNT_W{1'b0}};
            fifo_valid_r <= {DEPTH{1'b0}};
            busy_r       <= {REGS{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r      <= count_r + COUNT_W'(push_s) - COUNT_W'(pop_s);
            fifo_valid_r <= valid_next_s;
            busy_r       <= busy_next_s;
        end
    end

    // Registered write port; writes to register 0 are consumed but suppressed.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_r         <= 1'b0;
            write_address_r <= {ADDRESS_WIDTH{1'b0}};
            write_data_r    <= {WORD_WIDTH{1'b0}};
        end else begin
            write_r         <= sel_valid_s && (sel_addr_s != {ADDRESS_WIDTH{1'b0}});
            write_address_r <= sel_addr_s;
            write_data_r    <= sel_data_s;
        end
    end

    assign mem_ready     = mem_ready_s;
    assign write         = write_r;
    assign write_address = write_address_r;
    assign write_data    = write_data_r;
    assign busy          = busy_r;
    assign count         = count_r;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed self-checking bench for register_write_arbiter (default DEPTH = 2).
module tb_register_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_address;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_address;
    logic [31:0] mem_data;
    logic        write;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [31:0] busy;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;

    register_write_arbiter dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_address(alu_address), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_address(mem_address), .mem_data(mem_data),
        .write(write), .write_address(write_address), .write_data(write_data),
        .busy(busy), .count(count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_address = 5'd0; alu_data = 32'h0;
        mem_valid = 1'b0; mem_address = 5'd0; mem_data = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        mem_valid = 1'b1; mem_address = 5'd9; mem_data = 32'h1234;
        step(); step();
        checks++;
        if ({write, write_address, write_data} !== {1'b0, 5'd0, 32'h0}) begin
            errors++; $display("FAIL reset_write got %0b/%0d/%h exp 0/0/0", write, write_address, write_data);
        end
        checks++;
        if ({count, busy} !== {2'd0, 32'h0}) begin
            errors++; $display("FAIL reset_state got count %0d busy %h exp 0/0", count, busy);
        end
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %0b exp 0", mem_ready);
        end
        reset = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if ({write, mem_ready} !== 2'b01) begin
            errors++; $display("FAIL reset_release got write %0b ready %0b exp 0/1", write, mem_ready);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        step();
        mem_valid = 1'b1; mem_address = 5'd5; mem_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++; $display("FAIL bypass_ready got %0b exp 1", mem_ready);
        end
        step();
        idle_inputs();
        checks++;
        if ({write, write_address, write_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++; $display("FAIL bypass_write got %0b/%0d/%h exp 1/5/deadbeef", write, write_address, write_data);
        end
        checks++;
        if ({count, busy} !== {2'd0, 32'h0}) begin
            errors++; $display("FAIL bypass_count got count %0d busy %h exp 0/0", count, busy);
        end
        step();
        checks++;
        if (write !== 1'b0) begin
            errors++; $display("FAIL bypass_single got %0b exp 0", write);
        end
    endtask

    task automatic test_collision();
        idle_inputs();
        alu_valid = 1'b1; alu_address = 5'd3; alu_data = 32'h11;
        mem_valid = 1'b1; mem_address = 5'd4; mem_data = 32'h22;
        step();
        idle_inputs();
        checks++;
        if ({write, write_address, write_data} !== {1'b1, 5'd3, 32'h11}) begin
            errors++; $display("FAIL collision_alu got %0b/%0d/%h exp 1/3/11", write, write_address, write_data);
        end
        checks++;
        if ({count, busy} !== {2'd1, 32'h0000_0010}) begin
            errors++; $display("FAIL collision_busy got count %0d busy %h exp 1/00000010", count, busy);
        end
        step();
        checks++;
        if ({write, write_address, write_data} !== {1'b1, 5'd4, 32'h22}) begin
            errors++; $display("FAIL collision_load got %0b/%0d/%h exp 1/4/22", write, write_address, write_data);
        end
        checks++;
        if ({count, busy} !== {2'd0, 32'h0}) begin
            errors++; $display("FAIL collision_drain got count %0d busy %h exp 0/0", count, busy);
        end
    endtask

    task automatic test_full();
        logic [4:0]  exp_ready = 5'b10011;
        logic [1:0]  exp_count [8] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0};
        logic [37:0] exp_wr;
        int k = 0;
        for (int c = 0; c < 8; c++) begin
            alu_valid   = (c < 4);
            alu_address = 5'(10 + c);
            alu_data    = 32'hA0 + 32'(c);
            mem_valid   = (k < 3);
            mem_address = 5'(20 + k);
            mem_data    = 32'h100 + 32'(k);
            #1;
            if (c < 5) begin
                checks++;
                if (mem_ready !== exp_ready[c]) begin
                    errors++; $display("FAIL full_ready c%0d got %0b exp %0b", c, mem_ready, exp_ready[c]);
                end
            end
            if (mem_valid && exp_ready[c % 5] && c < 5) k++;
            step();
            if (c < 4) exp_wr = {1'b1, 5'(10 + c), 32'hA0 + 32'(c)};
            else exp_wr = {1'b1, 5'(16 + c), 32'hFC + 32'(c)};
            if (c < 7) begin
                checks++;
                if ({write, write_address, write_data} !== exp_wr) begin
                    errors++; $display("FAIL full_write c%0d got %0b/%0d/%h exp %h", c, write, write_address, write_data, exp_wr);
                end
            end else begin
                checks++;
                if (write !== 1'b0) begin
                    errors++; $display("FAIL full_idle got %0b exp 0", write);
                end
            end
            checks++;
            if (count !== exp_count[c]) begin
                errors++; $display("FAIL full_count c%0d got %0d exp %0d", c, count, exp_count[c]);
            end
            if (c == 1) begin
                checks++;
                if (busy !== 32'h0030_0000) begin
                    errors++; $display("FAIL full_busy got %h exp 00300000", busy);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_x0();
        idle_inputs();
        alu_valid = 1'b1; alu_address = 5'd0; alu_data = 32'h55;
        step();
        checks++;
        if (write !== 1'b0) begin
            errors++; $display("FAIL x0_alu got %0b exp 0", write);
        end
        alu_valid = 1'b1; alu_address = 5'd7; alu_data = 32'h1;
        mem_valid = 1'b1; mem_address = 5'd0; mem_data = 32'h77;
        step();
        idle_inputs();
        checks++;
        if ({write, write_address, count, busy} !== {1'b1, 5'd7, 2'd1, 32'h0}) begin
            errors++; $display("FAIL x0_push got %0b/%0d count %0d busy %h exp 1/7/1/0", write, write_address, count, busy);
        end
        step();
        checks++;
        if ({write, count} !== {1'b0, 2'd0}) begin
            errors++; $display("FAIL x0_pop got write %0b count %0d exp 0/0", write, count);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        alu_valid = 1'b1; alu_address = 5'd1; alu_data = 32'hA1;
        mem_valid = 1'b1; mem_address = 5'd8; mem_data = 32'h88;
        step();
        alu_address = 5'd2; alu_data = 32'hA2;
        mem_address = 5'd9; mem_data = 32'h99;
        step();
        checks++;
        if ({count, busy} !== {2'd2, 32'h0000_0300}) begin
            errors++; $display("FAIL mid_fill got count %0d busy %h exp 2/00000300", count, busy);
        end
        alu_valid = 1'b0;
        mem_address = 5'd6; mem_data = 32'h66;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++; $display("FAIL mid_ready got %0b exp 0", mem_ready);
        end
        step();
        checks++;
        if ({write, count, busy} !== {1'b0, 2'd0, 32'h0}) begin
            errors++; $display("FAIL mid_reset got write %0b count %0d busy %h exp 0/0/0", write, count, busy);
        end
        reset = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if ({write, mem_ready} !== 2'b01) begin
            errors++; $display("FAIL mid_release got write %0b ready %0b exp 0/1", write, mem_ready);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if ({write, count} !== {1'b0, 2'd0}) begin
                errors++; $display("FAIL mid_dropped c%0d got write %0b addr %0d count %0d exp 0/-/0", c, write, write_address, count);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data_tab [3] = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            mem_valid = 1'b1; mem_address = 5'(12 + c); mem_data = data_tab[c];
            step();
            checks++;
            if ({write, write_address, write_data, count} !== {1'b1, 5'(12 + c), data_tab[c], 2'd0}) begin
                errors++; $display("FAIL b2b_write c%0d got %0b/%0d/%h count %0d exp 1/%0d/%h/0", c, write, write_address, write_data, count, 12 + c, data_tab[c]);
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_bypass();
        test_collision();
        test_full();
        test_x0();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
